// File: rtl/ann_stream_pkg.sv
// Shared stream types and default slot geometry for the aggregator/disaggregator pair.
package ann_stream_pkg;

    localparam int DATA_WIDTH_DEF  = 11;
    localparam int FETCH_WIDTH_DEF = 4;

    typedef logic [DATA_WIDTH_DEF-1:0]                 word_t;
    typedef logic [FETCH_WIDTH_DEF*DATA_WIDTH_DEF-1:0] wide_t;

endpackage

// File: rtl/stream_skid_reg.sv
// Single-entry registered stage: accepts a word only when empty, so in_ready never
// depends combinationally on the consumer side.
module stream_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_pop
);

    assign in_ready = wrst_n & !out_valid;

    // Fill and drain are mutually exclusive: a fill needs out_valid=0, a pop needs out_valid=1.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/disaggregator.sv
// Splits wide words into single slots, LSB slot first, for the write side of async_fifo1.
// Define DISAGGREGATOR_PREFETCH_EN to register the sender pop behind a one-word prefetch stage.
module disaggregator
    import ann_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF
) (
    input  logic                              wclk,
    input  logic                              wrst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    output logic                              busy
);

    localparam int                WIDE_W   = FETCH_WIDTH * DATA_WIDTH;
    localparam int                IDX_W    = $clog2(FETCH_WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

    logic [WIDE_W-1:0] cur;
    logic [WIDE_W-1:0] load_data;
    logic              cur_v;
    logic [IDX_W-1:0]  idx;
    logic              last_enq;
    logic              load;

    // Handshake: a transfer happens on an edge where the producer's valid (empty_n/cur_v)
    // and the consumer's ready (deq/full_n) are both high; data is held until then.
    assign receiver_enq = wrst_n & cur_v & receiver_full_n;
    assign last_enq     = receiver_enq & (idx == LAST_IDX);

`ifdef DISAGGREGATOR_PREFETCH_EN
    logic              pf_v;
    logic              pf_ready;
    logic [WIDE_W-1:0] pf;

    stream_skid_reg #(
        .WIDTH(WIDE_W)
    ) u_prefetch (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .in_data   (sender_data),
        .in_valid  (sender_empty_n),
        .in_ready  (pf_ready),
        .out_data  (pf),
        .out_valid (pf_v),
        .out_pop   (load)
    );

    assign sender_deq = sender_empty_n & pf_ready;
    assign load       = pf_v & (!cur_v | last_enq);
    assign load_data  = pf;
    assign busy       = cur_v | pf_v;
`else
    assign sender_deq = wrst_n & sender_empty_n & (!cur_v | last_enq);
    assign load       = sender_deq;
    assign load_data  = sender_data;
    assign busy       = cur_v;
`endif

    // A load only coincides with a held word on its last-slot transfer, so idx restarts at 0.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            cur   <= '0;
            cur_v <= 1'b0;
            idx   <= '0;
        end else if (load) begin
            cur   <= load_data;
            cur_v <= 1'b1;
            idx   <= '0;
        end else if (receiver_enq) begin
            if (idx == LAST_IDX) begin
                cur_v <= 1'b0;
                idx   <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        receiver_data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (idx == IDX_W'(i)) receiver_data = cur[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule
